// File: rtl/matrix_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_host                                                                |
// | Collects two 3x3 byte matrices, launches an external multiplier and        |
// | streams the nine result bytes out. Optional: MATRIX_HOST_TIMEOUT_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module matrix_host #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] A00, A01, A02, A10, A11, A12, A20, A21, A22,
  output logic [7:0] B00, B01, B02, B10, B11, B12, B20, B21, B22,
  output logic       mm_load,
  input  logic       mm_done,
  input  logic [7:0] R00, R01, R02, R10, R11, R12, R20, R21, R22,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_COLLECT   = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  localparam logic [4:0] c_last_idx = 5'd17;
  localparam logic [3:0] c_last_k   = 4'd8;

  state_t     r_state;
  logic [4:0] r_idx;
  logic [3:0] r_k;
  logic [7:0] r_ab  [18];
  logic [7:0] r_buf [9];
  logic [7:0] r_out_data;
  logic       r_frame_done;
  logic [7:0] w_r   [9];
  logic       w_timeout;

`ifdef MATRIX_HOST_TIMEOUT_EN
  localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_timer;
  logic       r_err;
  logic [7:0] w_timer_next;

  assign w_timer_next = r_timer + 8'd1;
  assign w_timeout    = (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) &&
                        (w_timer_next == c_timeout);
  assign err          = r_err;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_timer <= 8'd0;
      r_err   <= 1'b0;
    end else if (r_state == S_LAUNCH) begin
      r_timer <= 8'd0;
    end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
      r_timer <= w_timer_next;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign in_ready   = (r_state == S_COLLECT);
  assign mm_load    = (r_state == S_LAUNCH);
  assign out_valid  = (r_state == S_DRAIN);
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

  assign A00 = r_ab[0];  assign A01 = r_ab[1];  assign A02 = r_ab[2];
  assign A10 = r_ab[3];  assign A11 = r_ab[4];  assign A12 = r_ab[5];
  assign A20 = r_ab[6];  assign A21 = r_ab[7];  assign A22 = r_ab[8];
  assign B00 = r_ab[9];  assign B01 = r_ab[10]; assign B02 = r_ab[11];
  assign B10 = r_ab[12]; assign B11 = r_ab[13]; assign B12 = r_ab[14];
  assign B20 = r_ab[15]; assign B21 = r_ab[16]; assign B22 = r_ab[17];

  assign w_r[0] = R00; assign w_r[1] = R01; assign w_r[2] = R02;
  assign w_r[3] = R10; assign w_r[4] = R11; assign w_r[5] = R12;
  assign w_r[6] = R20; assign w_r[7] = R21; assign w_r[8] = R22;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= S_COLLECT;
      r_idx        <= 5'd0;
      r_k          <= 4'd0;
      r_out_data   <= 8'd0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 18; i++) r_ab[i] <= 8'd0;
      for (int i = 0; i < 9; i++) r_buf[i] <= 8'd0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (in_valid) begin
            r_ab[r_idx] <= in_data;
            if (r_idx == c_last_idx) begin
              r_idx   <= 5'd0;
              r_state <= S_LAUNCH;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_LAUNCH: r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          // Wait for the multiplier to acknowledge the start before trusting done.
          if (w_timeout)     r_state <= S_COLLECT;
          else if (!mm_done) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_timeout) begin
            r_state <= S_COLLECT;
          end else if (mm_done) begin
            for (int i = 0; i < 9; i++) r_buf[i] <= w_r[i];
            r_out_data <= w_r[0];
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_k == c_last_k) begin
              r_k          <= 4'd0;
              r_frame_done <= 1'b1;
              r_state      <= S_COLLECT;
            end else begin
              r_k        <= r_k + 4'd1;
              r_out_data <= r_buf[r_k + 4'd1];
            end
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_host.sv
`default_nettype none
// Bench for matrix_host: vector table plus randomized frames against a
// matrix-product reference model, with a behavioural multiplier stub.
module tb_matrix_host;

  typedef logic [8:0][7:0] mat_t;
  typedef struct {
    mat_t a;
    mat_t b;
    mat_t exp;
    int   busy;
    int   bp_k;
  } vec_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       in_ready, mm_load, out_valid, frame_done, err;
  logic       mm_done = 1'b1;
  logic [7:0] out_data;
  logic [7:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
  logic [7:0] B00, B01, B02, B10, B11, B12, B20, B21, B22;
  logic [7:0] R00, R01, R02, R10, R11, R12, R20, R21, R22;
  mat_t       pa, pb;
  mat_t       stub_r = '0;

  int n_pass = 0;
  int n_total = 0;
  int load_cnt = 0;
  int busy_len = 2;
  int busy_cnt = 0;
  bit stuck = 1'b0;

  always #5 clk = ~clk;

  matrix_host #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .A00(A00), .A01(A01), .A02(A02), .A10(A10), .A11(A11), .A12(A12), .A20(A20), .A21(A21), .A22(A22),
    .B00(B00), .B01(B01), .B02(B02), .B10(B10), .B11(B11), .B12(B12), .B20(B20), .B21(B21), .B22(B22),
    .mm_load(mm_load), .mm_done(mm_done),
    .R00(R00), .R01(R01), .R02(R02), .R10(R10), .R11(R11), .R12(R12), .R20(R20), .R21(R21), .R22(R22),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .frame_done(frame_done), .err(err)
  );

  assign pa = {A22, A21, A20, A12, A11, A10, A02, A01, A00};
  assign pb = {B22, B21, B20, B12, B11, B10, B02, B01, B00};
  assign {R22, R21, R20, R12, R11, R10, R02, R01, R00} = stub_r;

  // Reference: plain 3x3 product, each element reduced mod 256.
  function automatic mat_t ref_mul(input mat_t a, input mat_t b);
    mat_t m;
    int   acc;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int k = 0; k < 3; k++) acc += int'(a[r*3+k]) * int'(b[k*3+c]);
        m[r*3+c] = 8'(acc % 256);
      end
    return m;
  endfunction

  function automatic logic [7:0] dot(input mat_t a, input mat_t b, input int i);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s += int'(a[(i/3)*3+k]) * int'(b[k*3+(i%3)]);
    return 8'(s);
  endfunction

  // Multiplier stub: busy for busy_len cycles after a load, or never responds when stuck.
  always @(posedge clk) begin
    if (Reset) begin
      mm_done  <= 1'b1;
      busy_cnt <= 0;
    end else if (mm_load && !stuck) begin
      for (int i = 0; i < 9; i++) stub_r[i] <= dot(pa, pb, i);
      mm_done  <= 1'b0;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      mm_done  <= 1'b1;
    end
    if (mm_load) load_cnt <= load_cnt + 1;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic feed(input mat_t a, input mat_t b, input int n);
    logic [17:0][7:0] ab;
    int i, guard;
    ab = {b, a};
    i = 0;
    guard = 0;
    while (i < n && guard < 500) begin
      @(negedge clk);
      guard++;
      in_valid = ($urandom_range(3) != 0);
      in_data  = ab[i];
      if (in_valid && in_ready) i++;
    end
    if (i < n) begin
      n_total++;
      $display("FAIL feed: accepted %0d of %0d bytes", i, n);
    end
  endtask

  task automatic drain(input mat_t exp, input int bp_k, input string tag);
    int k, guard, early_fd, bp;
    k = 0;
    guard = 0;
    early_fd = 0;
    bp = bp_k;
    while (k < 9 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (frame_done) early_fd++;
      if (out_valid && k == bp) begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          check({tag, "_hold"}, {out_valid, out_data}, {1'b1, exp[k]});
          @(negedge clk);
        end
        bp = -1;
      end
      out_ready = ($urandom_range(2) != 0);
      if (out_valid && out_ready) begin
        check($sformatf("%s_out%0d", tag, k), out_data, exp[k]);
        k++;
        if (k == 9) in_valid = 1'b0;
      end
    end
    if (k < 9) begin
      n_total++;
      $display("FAIL %s_drain: received %0d of 9 bytes", tag, k);
    end
    check({tag, "_early_fd"}, early_fd, 0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_fd"}, {frame_done, out_valid, in_ready}, 3'b101);
    @(negedge clk);
    check({tag, "_fd_end"}, frame_done, 1'b0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int l0;
    busy_len = v.busy;
    l0 = load_cnt;
    feed(v.a, v.b, 18);
    @(negedge clk);
    // Junk offered while not collecting must be ignored.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    drain(v.exp, v.bp_k, tag);
    check({tag, "_loads"}, load_cnt - l0, 1);
    check({tag, "_a_ports"}, pa, v.a);
    check({tag, "_b_ports"}, pb, v.b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    mat_t ident, seq, ra, rb;
    vec_t rv;
`ifdef MATRIX_HOST_TIMEOUT_EN
    int cyc;
    bit seen_ov;
`endif

    ident = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 9; i++) seq[i] = 8'(i + 1);
    tbl[0] = '{ident, seq, seq, 1, -1};
    tbl[1] = '{{9{8'd2}}, {9{8'd2}}, {9{8'd12}}, 3, 3};
    tbl[2] = '{{9{8'd16}}, {9{8'd16}}, {9{8'd0}}, 2, -1};
    ra = {8'd9, 8'd200, 8'd7, 8'd0, 8'd255, 8'd3, 8'd17, 8'd1, 8'd128};
    rb = {8'd5, 8'd6, 8'd250, 8'd33, 8'd0, 8'd4, 8'd99, 8'd2, 8'd11};
    tbl[3] = '{ra, rb, ref_mul(ra, rb), 5, 8};
    tbl[4] = '{rb, ra, ref_mul(rb, ra), 4, 0};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {in_ready, out_valid, mm_load, frame_done, err}, 5'b10000);
    check("rst_data", out_data, 8'd0);
    check("rst_a", pa, '0);
    check("rst_b", pb, '0);
    Reset = 1'b0;

    for (int t = 0; t < 5; t++) run_frame(tbl[t], $sformatf("vec%0d", t));

    // Abort a partially collected frame with reset.
    feed(tbl[3].a, tbl[3].b, 7);
    @(negedge clk);
    in_valid = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("abort_ctrl", {in_ready, out_valid, mm_load, frame_done}, 4'b1000);
    check("abort_a", pa, '0);
    run_frame(tbl[3], "after_abort");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 9; i++) begin
        rv.a[i] = 8'($urandom);
        rv.b[i] = 8'($urandom);
      end
      rv.exp  = ref_mul(rv.a, rv.b);
      rv.busy = int'($urandom_range(6, 1));
      rv.bp_k = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(8));
      run_frame(rv, $sformatf("rand%0d", t));
    end

`ifdef MATRIX_HOST_TIMEOUT_EN
    stuck = 1'b1;
    feed(tbl[1].a, tbl[1].b, 18);
    @(negedge clk);
    in_valid = 1'b0;
    check("to_launch", mm_load, 1'b1);
    cyc = 0;
    seen_ov = 1'b0;
    while (!err && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen_ov = 1'b1;
    end
    check("to_cycles", cyc, 65);
    check("to_no_output", seen_ov, 1'b0);
    check("to_collect", {in_ready, err}, 2'b11);
    repeat (3) @(negedge clk);
    check("to_sticky", err, 1'b1);
    stuck = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
`endif
    check("err_clear", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
